// File: rtl/frame_loader.sv
// frame_loader: turns a raster-order RGB565 byte stream into word writes for
// the two half-panel frame-memory banks read by the LED output driver.
// Rows 0 .. H/2-1 land in bank 0, rows H/2 .. H-1 in bank 1, and both banks
// share one word address and one data bus; only the strobes differ.
module frame_loader #(
  parameter  int MATRIX_HEIGHT = 32,
  parameter  int MATRIX_WIDTH  = 64,
  localparam int BANK_SIZE     = MATRIX_HEIGHT * MATRIX_WIDTH / 2,
  localparam int AW            = $clog2(BANK_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          w_en0,
  output logic          w_en1,
  output logic [AW-1:0] w_addr,
  output logic [15:0]   w_data,
  output logic          busy,
  output logic          frame_done
);

  localparam int HALF = MATRIX_HEIGHT / 2;
  localparam int RW   = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
  localparam int CW   = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_HALF = RW'(HALF);
  localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_WIDTH - 1);
  localparam logic [AW-1:0] WIDTH_A  = AW'(MATRIX_WIDTH);

  // HI waits for the high byte of a pixel, LO for the low byte that completes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [7:0]    hi_byte;

  logic          capture_hi;
  logic          issue_write;
  logic          last_pixel;
  logic          bank_sel;
  logic [RW-1:0] bank_row;
  logic [AW-1:0] addr_nxt;

  // Handshake and status come straight from the registered state, so they
  // change only one cycle after the start pulse.
  assign in_ready = (state != IDLE);
  assign busy     = (state != IDLE);

  // Position decode for the pixel currently being assembled.
  assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);
  assign bank_sel   = (row >= ROW_HALF);
  assign bank_row   = bank_sel ? (row - ROW_HALF) : row;
  assign addr_nxt   = AW'(bank_row) * WIDTH_A + AW'(col);

  // State register.
  // NOTE: every clocked assignment is non-blocking so all registers update
  // from the same pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; a start pulse overrides everything and restarts at HI.
  always_comb begin
    // NOTE: each signal gets its default before the case so that no path
    // leaves it unassigned and a latch cannot be inferred.
    state_nxt   = state;
    capture_hi  = 1'b0;
    issue_write = 1'b0;
    unique case (state)
      IDLE: state_nxt = IDLE;
      HI: begin
        if (in_valid) begin
          capture_hi = 1'b1;
          state_nxt  = LO;
        end
      end
      LO: begin
        if (in_valid) begin
          issue_write = 1'b1;
          state_nxt   = last_pixel ? IDLE : HI;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = HI;
  end

  // Pixel position counters and the pending high byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      hi_byte <= '0;
    end else begin
      if (capture_hi) hi_byte <= in_data;
      if (start) begin
        row <= '0;
        col <= '0;
      end else if (issue_write) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= last_pixel ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Registered write port; address and data hold between writes. A write
  // issued on a restart cycle still goes out, but its frame_done is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en0      <= 1'b0;
      w_en1      <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      frame_done <= 1'b0;
    end else begin
      w_en0      <= issue_write && !bank_sel;
      w_en1      <= issue_write && bank_sel;
      frame_done <= issue_write && last_pixel && !start;
      if (issue_write) begin
        w_addr <= addr_nxt;
        w_data <= {hi_byte, in_data};
      end
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader at the default 32x64 panel size.
module tb_frame_loader;

  localparam int H    = 32;
  localparam int W    = 64;
  localparam int BANK = H * W / 2;
  localparam int NPIX = H * W;

  typedef struct {
    logic        bank;
    logic [9:0]  addr;
    logic [15:0] data;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        w_en0;
  logic        w_en1;
  logic [9:0]  w_addr;
  logic [15:0] w_data;
  logic        busy;
  logic        frame_done;

  exp_t        exp_q[$];
  logic [15:0] mem0[BANK];
  logic [15:0] mem1[BANK];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          done_seen = 0;
  int          last_wr_cyc = -10;
  int          ab_writes = 0;

  frame_loader #(.MATRIX_HEIGHT(H), .MATRIX_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .w_en0      (w_en0),
    .w_en1      (w_en1),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and mirrors the banks.
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_exclusive", {31'd0, w_en0 & w_en1}, 0);
      check("done_needs_write", {31'd0, frame_done & !(w_en0 | w_en1)}, 0);
      if (!busy) check("ready_in_idle", {31'd0, in_ready}, 0);
      if (w_en0 || w_en1) begin
        check("write_expected", {31'd0, exp_q.size() != 0}, 1);
        check("write_gap", {31'd0, (cyc - last_wr_cyc) >= 2}, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("bank", {31'd0, w_en1}, {31'd0, e.bank});
          check("addr", {22'd0, w_addr}, {22'd0, e.addr});
          check("data", {16'd0, w_data}, {16'd0, e.data});
          check("done", {31'd0, frame_done}, {31'd0, e.done});
        end
        if (w_en0) mem0[w_addr] = w_data;
        else       mem1[w_addr] = w_data;
        if (w_data[15:8] == 8'hAB) ab_writes++;
        last_wr_cyc = cyc;
      end
      if (frame_done) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // Presents one byte and holds it until the block accepts it.
  task automatic drive_byte(input logic [7:0] b);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) check("accept_timeout", {31'd0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle_gap();
    if ($urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  // Pixel k carries word k; its bank and address follow from the raster index.
  task automatic send_pixel(input int p, input logic done_exp, input logic stall);
    exp_t        e;
    logic [15:0] word;
    word   = 16'(p);
    e.bank = (p >= BANK);
    e.addr = 10'(p % BANK);
    e.data = word;
    e.done = done_exp;
    exp_q.push_back(e);
    if (stall) idle_gap();
    drive_byte(word[15:8]);
    if (stall) idle_gap();
    drive_byte(word[7:0]);
  endtask

  task automatic send_frame(input logic stall);
    for (int p = 0; p < NPIX; p++) send_pixel(p, p == NPIX - 1, stall);
    repeat (2) tick();
  endtask

  task automatic clear_banks();
    for (int a = 0; a < BANK; a++) begin
      mem0[a] = 16'hFFFF;
      mem1[a] = 16'hFFFF;
    end
  endtask

  task automatic check_banks(input string tag);
    for (int a = 0; a < BANK; a++) begin
      check($sformatf("%s_bank0[%0d]", tag, a), {16'd0, mem0[a]}, a);
      check($sformatf("%s_bank1[%0d]", tag, a), {16'd0, mem1[a]}, BANK + a);
    end
  endtask

  initial begin
    int d0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check("rst_in_ready",   {31'd0, in_ready},   0);
    check("rst_w_en0",      {31'd0, w_en0},      0);
    check("rst_w_en1",      {31'd0, w_en1},      0);
    check("rst_w_addr",     {22'd0, w_addr},     0);
    check("rst_w_data",     {16'd0, w_data},     0);
    check("rst_busy",       {31'd0, busy},       0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    rst = 1'b0;
    tick();

    // Full frame with in_valid held high.
    clear_banks();
    d0 = done_seen;
    do_start();
    check("busy_after_start", {31'd0, busy}, 1);
    send_frame(1'b0);
    check("full_done_count", done_seen - d0, 1);
    check("full_done_latency", done_cyc - start_cyc, 2 * NPIX);
    check("half_last_top", {16'd0, mem0[BANK-1]}, BANK - 1);
    check("half_first_bottom", {16'd0, mem1[0]}, BANK);
    check_banks("full");
    check("idle_after_frame", {31'd0, busy}, 0);

    // Same frame with random gaps on in_valid.
    clear_banks();
    d0 = done_seen;
    do_start();
    send_frame(1'b1);
    check("stall_done_count", done_seen - d0, 1);
    check_banks("stall");

    // Restart with high byte 0xAB pending after 301 bytes.
    clear_banks();
    d0 = done_seen;
    ab_writes = 0;
    do_start();
    for (int p = 0; p < 150; p++) send_pixel(p, 1'b0, 1'b0);
    drive_byte(8'hAB);
    do_start();
    send_frame(1'b0);
    check("restart_no_ab_write", ab_writes, 0);
    check("restart_done_count", done_seen - d0, 1);
    check_banks("restart");

    // Reset pulsed after 500 bytes.
    d0 = done_seen;
    do_start();
    for (int p = 0; p < 250; p++) send_pixel(p, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 0);
    check("mid_rst_w_en0",    {31'd0, w_en0},    0);
    check("mid_rst_w_en1",    {31'd0, w_en1},    0);
    check("mid_rst_w_addr",   {22'd0, w_addr},   0);
    check("mid_rst_w_data",   {16'd0, w_data},   0);
    check("mid_rst_busy",     {31'd0, busy},     0);
    tick();
    rst = 1'b0;
    in_data  = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_ignored", {31'd0, in_ready}, 0);
    end
    in_valid = 1'b0;
    clear_banks();
    do_start();
    send_frame(1'b0);
    check("rst_frame_done_count", done_seen - d0, 1);
    check_banks("after_rst");

    // Start coincident with the final low byte.
    d0 = done_seen;
    do_start();
    for (int p = 0; p < NPIX - 1; p++) send_pixel(p, 1'b0, 1'b0);
    begin
      exp_t e;
      e.bank = 1'b1;
      e.addr = 10'd1023;
      e.data = 16'h07FF;
      e.done = 1'b0;
      exp_q.push_back(e);
    end
    drive_byte(8'h07);
    check("coincide_ready", {31'd0, in_ready}, 1);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("coincide_busy_next", {31'd0, busy}, 1);
    repeat (3) tick();
    check("coincide_no_done", done_seen - d0, 0);
    check("coincide_final_write", {16'd0, mem1[1023]}, 16'h07FF);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
